// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences byte/halfword/word accesses to a word-wide data memory.
// Optional macro LSU_MISALIGN_TRAP_EN makes misaligned halfword/word accesses return resp_err.
module lsu_ctrl #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]  state, state_n;
  logic        lat_we, lat_we_n;
  logic [1:0]  lat_size, lat_size_n;
  logic        lat_signed, lat_signed_n;
  logic [1:0]  lat_off, lat_off_n;
  logic [31:0] lat_wdata, lat_wdata_n;
  logic [31:0] buf_q, buf_n;
  logic        resp_valid_n, resp_err_n, mem_we_n;
  logic [31:0] resp_rdata_n, mem_a_n, mem_wd_n;
  logic        accept, misalign, req_sub;
  logic [29:0] word_idx;

  // Extract the addressed lane of a word and zero- or sign-extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/halfword lane of the old word with store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[31:16] = d[15:0];
        else        r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_sub   = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  assign word_idx  = 30'(req_addr[31:2] % 30'(MEM_WORDS));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    lat_we_n     = lat_we;
    lat_size_n   = lat_size;
    lat_signed_n = lat_signed;
    lat_off_n    = lat_off;
    lat_wdata_n  = lat_wdata;
    buf_n        = buf_q;
    resp_valid_n = resp_valid;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    mem_a_n      = mem_a;
    mem_wd_n     = mem_wd;
    mem_we_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lat_we_n     = req_we;
          lat_size_n   = req_size;
          lat_signed_n = req_signed;
          lat_off_n    = req_addr[1:0];
          lat_wdata_n  = req_wdata;
          mem_a_n      = {word_idx, 2'b00};
          if (misalign) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = 32'd0;
          end else if (req_we && !req_sub) begin
            state_n  = WR;
            mem_we_n = 1'b1;
            mem_wd_n = req_wdata;
          end else begin
            state_n = RD;
          end
        end
      end
      RD: begin
        buf_n = mem_rd;
        if (lat_we) begin
          state_n  = WR;
          mem_we_n = 1'b1;
          mem_wd_n = merge(buf_n, lat_wdata, lat_size, lat_off);
        end else begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = load_ext(buf_n, lat_size, lat_signed, lat_off);
        end
      end
      WR: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b0;
        resp_rdata_n = 32'd0;
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          resp_err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_off    <= 2'b00;
      lat_wdata  <= 32'd0;
      buf_q      <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_a      <= 32'd0;
      mem_wd     <= 32'd0;
      mem_we     <= 1'b0;
    end else begin
      state      <= state_n;
      lat_we     <= lat_we_n;
      lat_size   <= lat_size_n;
      lat_signed <= lat_signed_n;
      lat_off    <= lat_off_n;
      lat_wdata  <= lat_wdata_n;
      buf_q      <= buf_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      mem_a      <= mem_a_n;
      mem_wd     <= mem_wd_n;
      mem_we     <= mem_we_n;
    end
  end

endmodule
